// File: rtl/sobel_edge.sv
`default_nettype none
// ============================================================================
// Module      : sobel_edge
// Description : Streaming 3x3 Sobel edge detector with line buffers,
//               a two-stage gradient pipeline and frame-level control.
// Revision    : 1.0
// ============================================================================
module sobel_edge #(
  parameter int IMG_WIDTH  = 640,
  parameter int IMG_HEIGHT = 480,
  parameter int THRESHOLD  = 128
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_start,
  input  logic       i_valid,
  input  logic [9:0] i_gray,
  output logic       o_valid,
  output logic [9:0] o_mag,
  output logic       o_bw,
  output logic       o_busy,
  output logic       o_done
);

  localparam int c_COL_W = (IMG_WIDTH  > 1) ? $clog2(IMG_WIDTH)  : 1;
  localparam int c_ROW_W = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;
  localparam logic [c_COL_W-1:0] c_COL_LAST = c_COL_W'(IMG_WIDTH - 1);
  localparam logic [c_ROW_W-1:0] c_ROW_LAST = c_ROW_W'(IMG_HEIGHT - 1);
  localparam logic [c_COL_W-1:0] c_COL_TWO  = c_COL_W'(2);
  localparam logic [c_ROW_W-1:0] c_ROW_TWO  = c_ROW_W'(2);
  localparam logic [13:0]        c_THR      = 14'(THRESHOLD);
  localparam logic [13:0]        c_SAT      = 14'd1023;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACTIVE = 2'd1,
    S_DRAIN  = 2'd2
  } state_t;

  state_t               r_state;
  state_t               w_state_nxt;
  logic                 w_done_nxt;
  logic                 r_done;
  logic [c_COL_W-1:0]   r_col;
  logic [c_ROW_W-1:0]   r_row;
  logic                 w_accept;
  logic                 w_last;
  logic                 w_qual;

  logic [9:0]           r_lb1 [IMG_WIDTH];
  logic [9:0]           r_lb2 [IMG_WIDTH];
  logic [9:0]           r_win [3][3];

  logic                 r_win_vld;
  logic                 r_s1_vld;
  logic [12:0]          w_gx_p, w_gx_n, w_gy_p, w_gy_n;
  logic signed [12:0]   w_gx, w_gy;
  logic signed [12:0]   r_gx, r_gy;
  logic [12:0]          w_abs_x, w_abs_y;
  logic [13:0]          w_mag;

  logic                 r_out_vld;
  logic [9:0]           r_out_mag;
  logic                 r_out_bw;

  assign w_accept = (r_state == S_ACTIVE) && i_valid;
  assign w_last   = w_accept && (r_row == c_ROW_LAST) && (r_col == c_COL_LAST);
  assign w_qual   = w_accept && (r_row >= c_ROW_TWO) && (r_col >= c_COL_TWO);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= S_IDLE;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_done  <= w_done_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_done_nxt  = 1'b0;
    case (r_state)
      S_IDLE:   if (i_start) w_state_nxt = S_ACTIVE;
      S_ACTIVE: if (w_last)  w_state_nxt = S_DRAIN;
      S_DRAIN: begin
        // Last result leaves the output register on the same edge that
        // raises o_done, so o_done trails the final o_valid by one cycle.
        if (!r_win_vld && !r_s1_vld) begin
          w_state_nxt = S_IDLE;
          w_done_nxt  = 1'b1;
        end
      end
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_col <= '0;
      r_row <= '0;
    end else if ((r_state == S_IDLE) && i_start) begin
      r_col <= '0;
      r_row <= '0;
    end else if (w_accept) begin
      if (r_col == c_COL_LAST) begin
        r_col <= '0;
        r_row <= (r_row == c_ROW_LAST) ? '0 : r_row + 1'b1;
      end else begin
        r_col <= r_col + 1'b1;
      end
    end
  end

  // Line buffers and window hold no reset: rows 0-1 never qualify for output.
  always_ff @(posedge i_clk) begin
    if (w_accept) begin
      r_lb1[r_col] <= i_gray;
      r_lb2[r_col] <= r_lb1[r_col];
      for (int i = 0; i < 3; i++) begin
        r_win[i][0] <= r_win[i][1];
        r_win[i][1] <= r_win[i][2];
      end
      r_win[0][2] <= r_lb2[r_col];
      r_win[1][2] <= r_lb1[r_col];
      r_win[2][2] <= i_gray;
    end
  end

  assign w_gx_p = {3'b0, r_win[0][2]} + {2'b0, r_win[1][2], 1'b0} + {3'b0, r_win[2][2]};
  assign w_gx_n = {3'b0, r_win[0][0]} + {2'b0, r_win[1][0], 1'b0} + {3'b0, r_win[2][0]};
  assign w_gy_p = {3'b0, r_win[2][0]} + {2'b0, r_win[2][1], 1'b0} + {3'b0, r_win[2][2]};
  assign w_gy_n = {3'b0, r_win[0][0]} + {2'b0, r_win[0][1], 1'b0} + {3'b0, r_win[0][2]};
  assign w_gx   = $signed(w_gx_p - w_gx_n);
  assign w_gy   = $signed(w_gy_p - w_gy_n);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_win_vld <= 1'b0;
      r_s1_vld  <= 1'b0;
      r_gx      <= '0;
      r_gy      <= '0;
    end else begin
      r_win_vld <= w_qual;
      r_s1_vld  <= r_win_vld;
      r_gx      <= w_gx;
      r_gy      <= w_gy;
    end
  end

  assign w_abs_x = r_gx[12] ? (13'd0 - r_gx) : r_gx;
  assign w_abs_y = r_gy[12] ? (13'd0 - r_gy) : r_gy;
  assign w_mag   = {1'b0, w_abs_x} + {1'b0, w_abs_y};

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_out_vld <= 1'b0;
      r_out_mag <= '0;
      r_out_bw  <= 1'b0;
    end else begin
      r_out_vld <= r_s1_vld;
      r_out_mag <= !r_s1_vld ? 10'd0 : (w_mag > c_SAT) ? 10'd1023 : w_mag[9:0];
      r_out_bw  <= r_s1_vld && (w_mag > c_THR);
    end
  end

  assign o_valid = r_out_vld;
  assign o_mag   = r_out_mag;
  assign o_bw    = r_out_bw;
  assign o_done  = r_done;
  assign o_busy  = (r_state != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_sobel_edge.sv
`default_nettype none
// ============================================================================
// Module      : tb_sobel_edge
// Description : Directed self-checking bench for sobel_edge on an 8x6 frame.
// Revision    : 1.0
// ============================================================================
module tb_sobel_edge;

  localparam int c_W   = 8;
  localparam int c_H   = 6;
  localparam int c_THR = 128;
  localparam int c_NOUT = (c_W - 2) * (c_H - 2);

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       vld = 1'b0;
  logic [9:0] gray = '0;
  logic       o_valid, o_bw, o_busy, o_done;
  logic [9:0] o_mag;

  sobel_edge #(.IMG_WIDTH(c_W), .IMG_HEIGHT(c_H), .THRESHOLD(c_THR)) u_dut (
    .i_clk   (clk),
    .i_rst   (rst),
    .i_start (start),
    .i_valid (vld),
    .i_gray  (gray),
    .o_valid (o_valid),
    .o_mag   (o_mag),
    .o_bw    (o_bw),
    .o_busy  (o_busy),
    .o_done  (o_done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk = 0;
  int n_err = 0;
  int out_mag[$];
  int out_bw[$];
  int out_cyc[$];
  int acc_q[$];
  int done_cnt = 0;
  int done_cyc = 0;
  int idle_bad = 0;

  always @(negedge clk) begin
    if (o_valid) begin
      out_mag.push_back(int'(o_mag));
      out_bw.push_back(int'(o_bw));
      out_cyc.push_back(cyc);
    end else if (o_mag != 10'd0 || o_bw != 1'b0) begin
      idle_bad++;
    end
    if (o_done) begin
      done_cnt++;
      done_cyc = cyc;
    end
  end

  task automatic chk_eq(input string tag, input int got, input int exp);
    n_chk++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  // kind: 0 uniform 500, 1 step 0/100, 2 step 0/1023, 3 quadratic ramp
  function automatic int pix(input int kind, input int r, input int c);
    case (kind)
      0:       return 500;
      1:       return (c >= 4) ? 100 : 0;
      2:       return (c >= 4) ? 1023 : 0;
      default: return 8 * r * r + 7 * c;
    endcase
  endfunction

  function automatic int exp_mag(input int kind, input int cr, input int cc);
    case (kind)
      0:       return 0;
      1:       return (cc == 3 || cc == 4) ? 400 : 0;
      2:       return (cc == 3 || cc == 4) ? 1023 : 0;
      default: return 56 + 128 * cr;
    endcase
  endfunction

  function automatic int exp_bw(input int kind, input int cr, input int cc);
    case (kind)
      0:       return 0;
      1, 2:    return (cc == 3 || cc == 4) ? 1 : 0;
      default: return (56 + 128 * cr > c_THR) ? 1 : 0;
    endcase
  endfunction

  task automatic clear_log();
    out_mag.delete();
    out_bw.delete();
    out_cyc.delete();
    acc_q.delete();
    done_cnt = 0;
    idle_bad = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_frame(input string tag, input int kind, input bit gaps, input bit abuse);
    int cr, cc;
    clear_log();
    if (abuse) begin
      for (int k = 0; k < 5; k++) begin
        vld  = 1'b1;
        gray = 10'(k * 77 + 300);
        tick();
      end
      vld = 1'b0;
    end
    start = 1'b1;
    tick();
    start = 1'b0;
    chk_eq({tag, "_busy_active"}, int'(o_busy), 1);
    for (int r = 0; r < c_H; r++) begin
      for (int c = 0; c < c_W; c++) begin
        if (gaps) begin
          vld = 1'b0;
          repeat ($urandom_range(0, 3)) tick();
        end
        if (abuse && r == 1 && c == 3) begin
          vld   = 1'b0;
          start = 1'b1;
          tick();
          start = 1'b0;
        end
        vld  = 1'b1;
        gray = 10'(pix(kind, r, c));
        if (r >= 2 && c >= 2) acc_q.push_back(cyc + 1);
        tick();
      end
    end
    vld = 1'b0;
    if (abuse) begin
      for (int k = 0; k < 4; k++) begin
        vld  = 1'b1;
        gray = 10'(900 - k);
        tick();
      end
      vld = 1'b0;
    end
    for (int t = 0; t < 40 && done_cnt == 0; t++) tick();
    repeat (4) tick();

    chk_eq({tag, "_nout"}, out_mag.size(), c_NOUT);
    chk_eq({tag, "_done_cnt"}, done_cnt, 1);
    chk_eq({tag, "_idle_zero"}, idle_bad, 0);
    chk_eq({tag, "_busy_idle"}, int'(o_busy), 0);
    if (out_cyc.size() > 0)
      chk_eq({tag, "_done_order"}, (done_cnt > 0 && done_cyc >= out_cyc[$]) ? 1 : 0, 1);
    for (int i = 0; i < out_mag.size() && i < c_NOUT; i++) begin
      cr = 1 + i / (c_W - 2);
      cc = 1 + i % (c_W - 2);
      chk_eq($sformatf("%s_mag_r%0dc%0d", tag, cr, cc), out_mag[i], exp_mag(kind, cr, cc));
      chk_eq($sformatf("%s_bw_r%0dc%0d", tag, cr, cc), out_bw[i], exp_bw(kind, cr, cc));
      if (i < acc_q.size())
        chk_eq($sformatf("%s_lat_%0d", tag, i), out_cyc[i] - acc_q[i], 2);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1;
    repeat (3) tick();
    chk_eq("rst_valid", int'(o_valid), 0);
    chk_eq("rst_mag",   int'(o_mag),   0);
    chk_eq("rst_bw",    int'(o_bw),    0);
    chk_eq("rst_busy",  int'(o_busy),  0);
    chk_eq("rst_done",  int'(o_done),  0);
    rst = 1'b0;
    tick();

    run_frame("uniform", 0, 1'b0, 1'b0);
    run_frame("step100", 1, 1'b0, 1'b0);
    run_frame("stepsat", 2, 1'b0, 1'b0);
    run_frame("ramp",    3, 1'b0, 1'b0);
    run_frame("rampgap", 3, 1'b1, 1'b0);
    run_frame("abuse",   3, 1'b1, 1'b1);

    // Abort a frame with reset after 20 pixels.
    clear_log();
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k < 20; k++) begin
      vld  = 1'b1;
      gray = 10'(pix(1, k / c_W, k % c_W));
      tick();
    end
    vld = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    repeat (10) tick();
    chk_eq("abort_done", done_cnt, 0);
    chk_eq("abort_busy", int'(o_busy), 0);
    chk_eq("abort_valid", int'(o_valid), 0);

    run_frame("post_abort", 0, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/sobel_edge.md
SOBEL_EDGE -- requirements
Module: sobel_edge

Interface
REQ-001 SHALL have parameter IMG_WIDTH, default 640: pixels per line.
REQ-002 SHALL have parameter IMG_HEIGHT, default 480: lines per frame.
REQ-003 SHALL have parameter THRESHOLD, default 128: binarisation level for o_bw.
REQ-004 SHALL have port i_clk  input  1: single clock; all logic on its rising edge.
REQ-005 SHALL have port i_rst  input  1: synchronous, active-high reset.
REQ-006 SHALL have port i_start  input  1: one-cycle frame-start pulse.
REQ-007 SHALL have port i_valid  input  1: i_gray carries a pixel this cycle.
REQ-008 SHALL have port i_gray  input  10: unsigned grayscale pixel, raster order.
REQ-009 SHALL have port o_valid  output  1: o_mag and o_bw are valid this cycle.
REQ-010 SHALL have port o_mag  output  10: saturated gradient magnitude.
REQ-011 SHALL have port o_bw  output  1: edge flag.
REQ-012 SHALL have port o_busy  output  1: frame in progress.
REQ-013 SHALL have port o_done  output  1: one-cycle end-of-frame pulse.

Function
REQ-014 SHALL implement states IDLE, ACTIVE and DRAIN.
REQ-015 SHALL move IDLE->ACTIVE on i_start, clearing the row and column counters to 0.
REQ-016 SHALL ignore i_valid in IDLE and DRAIN, and ignore i_start outside IDLE.
REQ-017 SHALL, in ACTIVE, accept a pixel on each i_valid cycle, with no backpressure and arbitrary gaps.
REQ-018 SHALL increment the column counter per accepted pixel and wrap it at IMG_WIDTH-1 to 0, incrementing the row.
REQ-019 SHALL hold two line buffers of IMG_WIDTH x 10 bits (rows r-1, r-2) plus a 3x3 window register, all shifted only on accepted pixels.
REQ-020 SHALL compute Gx = (p[0][2]+2p[1][2]+p[2][2]) - (p[0][0]+2p[1][0]+p[2][0]), with row 0 oldest and column 2 newest.
REQ-021 SHALL compute Gy = (p[2][0]+2p[2][1]+p[2][2]) - (p[0][0]+2p[0][1]+p[0][2]).
REQ-022 SHALL hold Gx and Gy as 13-bit signed values, with no overflow.
REQ-023 SHALL form magnitude = |Gx|+|Gy| (14-bit unsigned) and saturate it to 1023 for o_mag.
REQ-024 SHALL drive o_bw = 1 iff the unsaturated magnitude > THRESHOLD.
REQ-025 SHALL produce an output only when the accepted pixel has row>=2 and col>=2; the result belongs to centre pixel (row-1, col-1).
REQ-026 SHALL NOT produce outputs for border pixels; each frame yields exactly (IMG_HEIGHT-2)*(IMG_WIDTH-2) outputs.
REQ-027 SHALL use a two-stage output pipeline: o_valid asserts exactly 2 cycles after the qualifying accepted pixel, independent of input gaps.
REQ-028 SHALL emit outputs in raster order of their centre pixels.
REQ-029 SHALL move ACTIVE->DRAIN on accepting pixel (IMG_HEIGHT-1, IMG_WIDTH-1).
REQ-030 SHALL leave DRAIN when the pipeline is empty, pulse o_done for 1 cycle, and return to IDLE.
REQ-031 SHALL drive o_busy high in ACTIVE and DRAIN, and low in IDLE.
REQ-032 SHALL hold o_mag and o_bw at 0 whenever o_valid is 0.
REQ-033 SHALL NOT accept a new frame while in DRAIN; the frame's last o_valid precedes or coincides with o_done.

Reset
REQ-034 SHALL, on i_rst, force state to IDLE, clear counters and pipeline valid bits, and drive o_valid, o_mag, o_bw, o_busy and o_done to 0 on the next edge.
REQ-035 SHALL NOT require line-buffer contents to be reset; stale data never reaches the output because rows 0-1 produce nothing.
REQ-036 SHALL, on reset mid-frame, discard the in-flight frame and emit no o_done for it; the next i_start begins a clean frame.

Verification (IMG_WIDTH=8, IMG_HEIGHT=6, THRESHOLD=128)
REQ-037 Uniform frame, all pixels 500 -> exactly 24 outputs, all o_mag=0 and o_bw=0, then one o_done.
REQ-038 Vertical step, cols 0-3 = 0 and cols 4-7 = 100 -> o_mag=400 and o_bw=1 at centre cols 3 and 4, and 0 elsewhere.
REQ-039 Vertical step 0/1023 -> o_mag saturates to 1023 at the edge columns and o_bw=1.
REQ-040 Random i_valid gaps on a ramp frame -> outputs bit-identical to the gap-free run, each o_valid exactly 2 cycles after its qualifying pixel.
REQ-041 i_rst asserted after 20 pixels, then a fresh uniform frame -> no o_done for the aborted frame; 24 zero outputs and one o_done for the new frame.
REQ-042 i_start pulsed during ACTIVE, and i_valid driven while IDLE -> counters unchanged and no extra outputs.
